// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory side of the writeback path.
// Accepts one load or store at a time from the execute stage, holds it for
// WAIT_STATES extra cycles, then performs it on an internal word-addressed
// RAM. Busy stalls the pipeline, Done flags completion, and AddrErr flags a
// request that was refused (conflict, misaligned or out of range).
module mem_access_unit #(
   parameter int AWIDTH      = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [AWIDTH-1:0] Addr,
   input  logic [AWIDTH-1:0] WrDat,
   output logic [AWIDTH-1:0] ReaDat,
   output logic              Busy,
   output logic              Done,
   output logic              AddrErr
);

   localparam int IW = $clog2(DEPTH);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t            state;
   logic [3:0]        wait_cnt;
   logic              op_write;
   logic [IW-1:0]     idx;
   logic [AWIDTH-1:0] wdat;
   logic [AWIDTH-1:0] mem [DEPTH];

   // Request classification, evaluated only when the FSM is idle.
   logic              req;
   logic              conflict;
   logic              misaligned;
   logic              out_of_range;
   logic              reject;
   logic [AWIDTH-1:0] word_addr;
   logic              ram_we;

   assign req          = MemRead | MemWrite;
   assign conflict     = MemRead & MemWrite;
   assign misaligned   = (Addr[1:0] != 2'b00);
   assign word_addr    = Addr >> 2;
   // Full-width compare so that high address bits cannot alias into the RAM.
   assign out_of_range = (word_addr >= AWIDTH'(DEPTH));
   assign reject       = conflict | misaligned | out_of_range;

   // A store commits on the final WAIT edge, unless reset lands on that edge.
   assign ram_we = !rst && (state == S_WAIT) && (wait_cnt == 4'd0) && op_write;

   // Control FSM: request capture, wait-state countdown and registered outputs.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         wait_cnt <= 4'd0;
         op_write <= 1'b0;
         idx      <= '0;
         wdat     <= '0;
         ReaDat   <= '0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         AddrErr  <= 1'b0;
      end else begin
         Done    <= 1'b0;
         AddrErr <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  if (reject) begin
                     AddrErr <= 1'b1;
                  end else begin
                     op_write <= MemWrite;
                     idx      <= Addr[IW+1:2];
                     wdat     <= WrDat;
                     wait_cnt <= 4'(WAIT_STATES);
                     state    <= S_WAIT;
                     Busy     <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end else begin
                  if (!op_write) begin
                     ReaDat <= mem[idx];
                  end
                  state <= S_IDLE;
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Data RAM write port.
   // NOTE: the RAM array is deliberately left out of reset; clearing it would
   // force flops instead of a RAM macro, and contents must survive reset.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[idx] <= wdat;
      end
   end

endmodule
